sap_prog_loader: RTL and testbench
==================================

// Module: sap_prog_loader
// PURPOSE
//  Sequences program download into SAP-1 16x8 RAM and arbitrates the RAM write port between
//  loader and CPU. On load_start it holds the CPU (cpu_hold drives control-logic reset) and
//  consumes a byte stream (valid/ready): header, data bytes, XOR checksum. After a good
//  checksum it releases the CPU; on a bad checksum it keeps the CPU held and flags err.
// PARAMETERS
//  ADDR_W          4  RAM address width (RAM depth = 2**ADDR_W)
//  DATA_W          8  RAM/stream data width
//  RELEASE_CYCLES  2  cycles cpu_hold stays high after checksum pass (1..15)
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       synchronous, active-high
//  load_start     in   1       start download; sampled only in IDLE or ERR
//  in_valid       in   1       stream byte valid
//  in_data        in   DATA_W  stream byte
//  in_ready       out  1       loader accepts byte this cycle (accept = in_valid & in_ready)
//  cpu_ram_addr   in   ADDR_W  CPU-side RAM address (from MAR)
//  cpu_ram_we     in   1       CPU-side RAM write (ram_latch)
//  cpu_ram_wdata  in   DATA_W  CPU-side write data (bus)
//  ram_addr       out  ADDR_W  to RAM
//  ram_we         out  1       to RAM
//  ram_wdata      out  DATA_W  to RAM
//  cpu_hold       out  1       hold CPU in reset
//  busy           out  1       download in progress (HDR/DATA/CHK/REL)
//  done           out  1       sticky: last download passed checksum
//  err            out  1       sticky: last download failed checksum
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=0, cpu_hold=0, busy=0, done=0, err=0; wptr, remaining, chk = 0.
//  - States IDLE, HDR, DATA, CHK, REL, ERR; all registered; outputs decoded from state.
//  - RAM mux (combinational, zero latency): cpu_hold=0 -> ram_* = cpu_ram_*; cpu_hold=1 ->
//    ram_addr=wptr, ram_wdata=in_data, ram_we = accept & (state==DATA). CPU writes are dropped
//    while held.
//  - IDLE: load_start -> HDR next cycle; done,err cleared; cpu_hold,busy rise with HDR.
//  - HDR: in_ready=1. Accept: wptr<=in_data[3:0], remaining<=in_data[7:4]+1 (1..16, 5-bit),
//    chk<=0 -> DATA.
//  - DATA: in_ready=1. Accept: RAM written same cycle at wptr; wptr<=wptr+1 mod 16 (wraps 15->0);
//    chk<=chk^in_data; remaining<=remaining-1; accept with remaining==1 -> CHK.
//  - CHK: in_ready=1. Accept: in_data==chk -> REL; else -> ERR (err<=1). No RAM write.
//  - REL: in_ready=0, cpu_hold=1 for exactly RELEASE_CYCLES cycles, then IDLE with done<=1;
//    cpu_hold=0 and busy=0 from first IDLE cycle.
//  - ERR: in_ready=0, busy=0, cpu_hold stays 1 (no run of corrupt image); load_start -> HDR
//    (retry, err cleared). Only reset or successful retry releases CPU.
//  - in_valid while in_ready=0: byte not consumed; source holds it.
//  - load_start while busy: ignored. load_start and in_valid same cycle in IDLE: byte not
//    consumed (in_ready=0 in IDLE).
//  - No timeout: stalled stream keeps loader in current state indefinitely.
//  - Reset mid-download: immediate return to reset state next edge; partially written RAM
//    contents are not restored; cpu_hold drops.
// TESTING
//  1 load_start; stream 0x10,0x1E,0x2F,chk 0x31 -> RAM[0]=0x1E,RAM[1]=0x2F; done=1,
//    cpu_hold low RELEASE_CYCLES+1 cycles after chk accept.
//  2 Header 0x1F (start 15, 2 bytes) data 0xAA,0x55 -> RAM[15]=0xAA, RAM[0]=0x55 (wrap).
//  3 Header 0x00, data 0x0E, chk 0x00 (bad) -> err=1, done=0, cpu_hold stays 1; retry with
//    correct chk 0x0E -> err=0, done=1, cpu_hold released.
//  4 Header 0xF0 (16 bytes), random in_valid gaps -> all 16 written in order, no byte lost or
//    duplicated; in_ready never high in IDLE/REL/ERR.
//  5 cpu_ram_we=1 at addr 3 while cpu_hold=1 -> RAM[3] unchanged; same after release -> written.
//  6 reset asserted after 2nd data byte -> next cycle IDLE, all outputs at reset values;
//    load_start mid-download ignored.

Source files
------------

// File: rtl/sap_prog_loader.sv
// SAP-1 program loader: streams header/data/checksum into the 16x8 RAM while holding
// the CPU in reset, then arbitrates the RAM write port back to the CPU.
module sap_prog_loader #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic              cpu_ram_we,
  input  logic [DATA_W-1:0] cpu_ram_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_REL  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] WPTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [3:0]        REL_LAST = 4'(RELEASE_CYCLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_chk;
  logic [3:0]        r_rel_cnt;
  logic              r_in_ready;
  logic              r_cpu_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_accept;

  assign w_accept = in_valid & r_in_ready;

  assign in_ready = r_in_ready;
  assign cpu_hold = r_cpu_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

  // Download FSM; status outputs are registered alongside each state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_remaining <= '0;
      r_chk       <= '0;
      r_rel_cnt   <= 4'd0;
      r_in_ready  <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state    <= S_HDR;
            r_in_ready <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_wptr      <= in_data[ADDR_W-1:0];
            r_remaining <= {1'b0, in_data[DATA_W-1 -: ADDR_W]} + REM_ONE;
            r_chk       <= '0;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_wptr      <= r_wptr + WPTR_ONE;
            r_chk       <= r_chk ^ in_data;
            r_remaining <= r_remaining - REM_ONE;
            if (r_remaining == REM_ONE) begin
              r_state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (in_data == r_chk) begin
              r_state   <= S_REL;
              r_rel_cnt <= 4'd0;
            end else begin
              // CPU stays held so a corrupt image never runs.
              r_state <= S_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
        end
        S_REL: begin
          if (r_rel_cnt == REL_LAST) begin
            r_state    <= S_IDLE;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_rel_cnt <= r_rel_cnt + 4'd1;
          end
        end
        S_ERR: begin
          if (load_start) begin
            r_state    <= S_HDR;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_cpu_hold <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // RAM write-port mux: loader owns the port whenever the CPU is held.
  always_comb begin
    ram_addr  = cpu_ram_addr;
    ram_we    = cpu_ram_we;
    ram_wdata = cpu_ram_wdata;
    if (r_cpu_hold) begin
      ram_addr  = r_wptr;
      ram_wdata = in_data;
      ram_we    = w_accept & (r_state == S_DATA);
    end else begin
      ram_addr  = cpu_ram_addr;
      ram_we    = cpu_ram_we;
      ram_wdata = cpu_ram_wdata;
    end
  end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Directed bench for sap_prog_loader with a behavioural 16x8 RAM on the write port.
module tb_sap_prog_loader;

  logic       clk;
  logic       reset;
  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] cpu_ram_addr;
  logic       cpu_ram_we;
  logic [7:0] cpu_ram_wdata;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] mem [16];
  int checks;
  int errors;
  logic [7:0] stream [16];
  logic [7:0] xsum;

  sap_prog_loader #(.ADDR_W(4), .DATA_W(8), .RELEASE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_ram_addr(cpu_ram_addr), .cpu_ram_we(cpu_ram_we), .cpu_ram_wdata(cpu_ram_wdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte from a negedge, hold it until accepted, return at the next negedge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, in_ready, cpu_hold, busy, done, err}, {27'd0, exp});
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_ram_addr = 4'd0; cpu_ram_we = 1'b0; cpu_ram_wdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // status vector order: in_ready, cpu_hold, busy, done, err
    check_status("reset_state", 5'b00000);

    // 1: basic download
    pulse_start();
    check_status("t1_hdr", 5'b11100);
    send(8'h10, 0); send(8'h1E, 0); send(8'h2F, 0); send(8'h31, 0);
    check_status("t1_rel0", 5'b01100);
    @(negedge clk);
    check_status("t1_rel1", 5'b01100);
    @(negedge clk);
    check_status("t1_idle", 5'b00010);
    check("t1_ram0", {24'd0, mem[0]}, 32'h1E);
    check("t1_ram1", {24'd0, mem[1]}, 32'h2F);
    // valid while idle is not consumed
    in_valid = 1'b1; in_data = 8'h99; load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("t1_idle_byte_held", {31'd0, in_ready}, 32'd1);
    check("t1_idle_noram", {24'd0, mem[2]}, 32'h00);
    in_valid = 1'b0;

    // 2: address wrap 15 -> 0
    send(8'h1F, 0); send(8'hAA, 0); send(8'h55, 0); send(8'hFF, 0);
    repeat (2) @(negedge clk);
    check("t2_ram15", {24'd0, mem[15]}, 32'hAA);
    check("t2_ram0", {24'd0, mem[0]}, 32'h55);
    check_status("t2_done", 5'b00010);

    // 3: bad checksum then retry
    pulse_start();
    send(8'h00, 0); send(8'h0E, 0); send(8'h00, 0);
    check_status("t3_err", 5'b01001);
    repeat (3) @(negedge clk);
    check_status("t3_err_stays", 5'b01001);
    pulse_start();
    check_status("t3_retry_hdr", 5'b11100);
    send(8'h00, 0); send(8'h0E, 0); send(8'h0E, 0);
    repeat (2) @(negedge clk);
    check_status("t3_retry_done", 5'b00010);
    check("t3_ram0", {24'd0, mem[0]}, 32'h0E);

    // 5: CPU writes dropped while held, honoured after release
    pulse_start();
    cpu_ram_addr = 4'd3; cpu_ram_wdata = 8'h77; cpu_ram_we = 1'b1;
    @(negedge clk);
    cpu_ram_we = 1'b0;
    check("t5_held_drop", {24'd0, mem[3]}, 32'h00);
    send(8'h05, 0); send(8'h33, 0); send(8'h33, 0);
    repeat (2) @(negedge clk);
    check("t5_ram5", {24'd0, mem[5]}, 32'h33);
    cpu_ram_we = 1'b1;
    check("t5_mux_addr", {28'd0, ram_addr}, 32'd3);
    @(negedge clk);
    cpu_ram_we = 1'b0;
    check("t5_cpu_write", {24'd0, mem[3]}, 32'h77);

    // 4: 16-byte image with random valid gaps
    xsum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      stream[i] = 8'(i * 37 + 11);
      xsum = xsum ^ stream[i];
    end
    pulse_start();
    send(8'hF0, $urandom_range(0, 2));
    for (int i = 0; i < 16; i++) send(stream[i], $urandom_range(0, 3));
    send(xsum, $urandom_range(0, 2));
    check("t4_rel_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check_status("t4_done", 5'b00010);
    for (int i = 0; i < 16; i++) check($sformatf("t4_ram%0d", i), {24'd0, mem[i]}, {24'd0, stream[i]});

    // 6: load_start ignored mid-download, then reset after second data byte
    pulse_start();
    send(8'h28, 0); send(8'h11, 0);
    pulse_start();
    check_status("t6_busy", 5'b11100);
    send(8'h22, 0);
    check("t6_ram9", {24'd0, mem[9]}, 32'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_status("t6_reset", 5'b00000);
    check("t6_ram8_kept", {24'd0, mem[8]}, 32'h11);
    check("t6_ram10", {24'd0, mem[10]}, {24'd0, stream[10]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
